// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: the inst/data requester ports and the bridge port
// that sram_bus_arbiter connects to.
// The signal names match the original flat port list of the arbiter.
// slave  : the arbiter's view. It takes requests and drives the bridge.
// master : the environment's view. This is the pipeline stages plus the bridge.
interface sram_bus_arbiter_if;
  // fetch-stage requester
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // EXE-stage data requester
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  // shared port towards the sram-to-AXI bridge
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like port between the fetch requester
// and the EXE data requester.
// At most one address handshake is granted per cycle. Each accepted
// request's owner (0=inst, 1=data) goes into an in-order tag FIFO, and the
// FIFO routes each returning data_ok/rdata back to the owner.
// The IDLE state grants combinationally. If the bridge stalls, the arbiter
// enters LOCK and holds the granted request stable until it is accepted.
// Optional macro ARB_ROUND_ROBIN_EN: when it is defined, a contested grant
// uses round-robin arbitration. When it is undefined, data has fixed
// priority over inst.
module sram_bus_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_bus_arbiter_if.slave     bus_if,
  output logic [CNT_W-1:0]      outstanding
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } state_t;

  state_t                 r_state;
  logic                   r_grant;
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;
  logic [OUTSTANDING-1:0] r_tags;

  logic w_full;
  logic w_empty;
  logic w_winner;
  logic w_sel;
  logic w_bus_req;
  logic w_push;
  logic w_pop;
  logic w_head_tag;

  assign w_full     = (r_count == CNT_W'(OUTSTANDING));
  assign w_empty    = (r_count == '0);
  assign w_head_tag = r_tags[r_head];

`ifdef ARB_ROUND_ROBIN_EN
  logic r_rr_last;

  // Contested grant goes to the requester that did not win last time.
  always_comb begin
    w_winner = bus_if.data_req;
    if (bus_if.inst_req && bus_if.data_req) begin
      w_winner = ~r_rr_last;
    end
  end

  // Remember the owner of the most recently accepted request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_last <= 1'b0;
    end else if (w_push) begin
      r_rr_last <= w_sel;
    end
  end
`else
  // Fixed priority: data wins whenever it is requesting.
  assign w_winner = bus_if.data_req;
`endif

  // Select the granted master and decide whether a request goes to the bridge.
  always_comb begin
    w_sel     = w_winner;
    w_bus_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_bus_req = !w_full && (bus_if.inst_req || bus_if.data_req);
      end
      ST_LOCK: begin
        w_sel     = r_grant;
        w_bus_req = r_grant ? bus_if.data_req : bus_if.inst_req;
      end
      default: begin
        w_bus_req = 1'b0;
      end
    endcase
    // During reset the request path is quiet, even with requesters active.
    if (!resetn) begin
      w_bus_req = 1'b0;
    end
  end

  assign w_push = w_bus_req && bus_if.bus_addr_ok;
  assign w_pop  = bus_if.bus_data_ok && !w_empty;

  assign bus_if.bus_req   = w_bus_req;
  assign bus_if.bus_wr    = w_sel ? bus_if.data_wr    : bus_if.inst_wr;
  assign bus_if.bus_size  = w_sel ? bus_if.data_size  : bus_if.inst_size;
  assign bus_if.bus_wstrb = w_sel ? bus_if.data_wstrb : bus_if.inst_wstrb;
  assign bus_if.bus_addr  = w_sel ? bus_if.data_addr  : bus_if.inst_addr;
  assign bus_if.bus_wdata = w_sel ? bus_if.data_wdata : bus_if.inst_wdata;

  assign bus_if.inst_addr_ok = w_push && !w_sel;
  assign bus_if.data_addr_ok = w_push &&  w_sel;

  // A response with no outstanding tag is dropped, so it gives no pulse.
  assign bus_if.inst_data_ok = w_pop && !w_head_tag;
  assign bus_if.data_data_ok = w_pop &&  w_head_tag;
  assign bus_if.inst_rdata   = bus_if.bus_rdata;
  assign bus_if.data_rdata   = bus_if.bus_rdata;

  assign outstanding = r_count;

  // Grant FSM: IDLE grants combinationally; LOCK holds a stalled grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_bus_req && !bus_if.bus_addr_ok) begin
            r_grant <= w_sel;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          // Leave LOCK on acceptance, or when the locked master drops its request.
          if (!w_bus_req || bus_if.bus_addr_ok) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag FIFO: push the owner on accept, pop on each bridge response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tags  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_tail] <= w_sel;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed scoreboard bench for sram_bus_arbiter.
// The driver pushes the expected address handshakes and responses into
// queues. A negedge monitor pops them and compares whenever the DUT pulses
// *_addr_ok or *_data_ok.
module tb_sram_bus_arbiter;

  logic       clk;
  logic       resetn;
  logic [2:0] outstanding;

  sram_bus_arbiter_if u_if ();

  sram_bus_arbiter #(
    .OUTSTANDING (4),
    .CNT_W       (3)
  ) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus_if      (u_if),
    .outstanding (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          who;   // 0=inst, 1=data
    logic [31:0] val;   // bus_addr for handshakes, rdata for responses
  } exp_t;

  exp_t addr_q[$];
  exp_t resp_q[$];
  bit   tag_q[$];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_accept(input bit who, input logic [31:0] addr);
    addr_q.push_back('{who: who, val: addr});
    tag_q.push_back(who);
  endtask

  task automatic exp_resp(input logic [31:0] rd);
    if (tag_q.size() > 0) begin
      resp_q.push_back('{who: tag_q.pop_front(), val: rd});
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    u_if.inst_req    = 1'b0;
    u_if.inst_wr     = 1'b0;
    u_if.inst_size   = 2'd2;
    u_if.inst_wstrb  = 4'hf;
    u_if.inst_addr   = '0;
    u_if.inst_wdata  = '0;
    u_if.data_req    = 1'b0;
    u_if.data_wr     = 1'b0;
    u_if.data_size   = 2'd2;
    u_if.data_wstrb  = 4'hf;
    u_if.data_addr   = '0;
    u_if.data_wdata  = '0;
    u_if.bus_addr_ok = 1'b0;
    u_if.bus_data_ok = 1'b0;
    u_if.bus_rdata   = '0;
  endtask

  // One bridge response cycle with the given rdata.
  task automatic respond(input logic [31:0] rd);
    u_if.bus_data_ok = 1'b1;
    u_if.bus_rdata   = rd;
    exp_resp(rd);
    @(negedge clk);
    next_cyc();
    u_if.bus_data_ok = 1'b0;
  endtask

  // One single-requester cycle that the bridge accepts immediately.
  task automatic accept_one(input bit who, input logic [31:0] addr);
    u_if.inst_req    = !who;
    u_if.data_req    = who;
    if (who) u_if.data_addr = addr;
    else     u_if.inst_addr = addr;
    u_if.bus_addr_ok = 1'b1;
    exp_accept(who, addr);
    @(negedge clk);
    next_cyc();
    u_if.inst_req    = 1'b0;
    u_if.data_req    = 1'b0;
    u_if.bus_addr_ok = 1'b0;
  endtask

  task automatic drained(input string name);
    chk({name, "_addr_q"}, addr_q.size(), 0);
    chk({name, "_resp_q"}, resp_q.size(), 0);
  endtask

  // Monitor: check every handshake and response pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (u_if.inst_addr_ok || u_if.data_addr_ok) begin
      if (addr_q.size() == 0) begin
        chk("addr_ok_spurious", {30'b0, u_if.inst_addr_ok, u_if.data_addr_ok}, 0);
      end else begin
        e = addr_q.pop_front();
        chk("addr_ok_owner", {30'b0, u_if.inst_addr_ok, u_if.data_addr_ok}, e.who ? 32'd1 : 32'd2);
        chk("bus_addr", u_if.bus_addr, e.val);
      end
    end
    if (u_if.inst_data_ok || u_if.data_data_ok) begin
      if (resp_q.size() == 0) begin
        chk("data_ok_spurious", {30'b0, u_if.inst_data_ok, u_if.data_data_ok}, 0);
      end else begin
        e = resp_q.pop_front();
        chk("data_ok_owner", {30'b0, u_if.inst_data_ok, u_if.data_data_ok}, e.who ? 32'd1 : 32'd2);
        chk("rdata", e.who ? u_if.data_rdata : u_if.inst_rdata, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  pat;
    logic [31:0] ia;
    logic [31:0] da;
    bit          who;

    // ---- reset state, with requests and addr_ok present during reset
    resetn = 1'b0;
    idle_in();
    u_if.inst_req    = 1'b1;
    u_if.data_req    = 1'b1;
    u_if.bus_addr_ok = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", u_if.bus_req, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_addr_ok", {u_if.inst_addr_ok, u_if.data_addr_ok}, 0);
    next_cyc();
    idle_in();
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_bus_req", u_if.bus_req, 0);
    next_cyc();

    // ---- simultaneous requests: data first, then inst
    u_if.inst_req    = 1'b1;
    u_if.inst_addr   = 32'h1c00_0000;
    u_if.inst_size   = 2'd2;
    u_if.inst_wstrb  = 4'hf;
    u_if.data_req    = 1'b1;
    u_if.data_addr   = 32'h0000_1000;
    u_if.data_wr     = 1'b1;
    u_if.data_size   = 2'd0;
    u_if.data_wstrb  = 4'h1;
    u_if.data_wdata  = 32'hdead_beef;
    u_if.bus_addr_ok = 1'b1;
    exp_accept(1'b1, 32'h0000_1000);
    @(negedge clk);
    chk("sim_bus_req", u_if.bus_req, 1);
    chk("sim_ctl_data", {u_if.bus_wr, u_if.bus_size, u_if.bus_wstrb}, {1'b1, 2'd0, 4'h1});
    chk("sim_wdata", u_if.bus_wdata, 32'hdead_beef);
    next_cyc();
    u_if.data_req = 1'b0;
    u_if.data_wr  = 1'b0;
    exp_accept(1'b0, 32'h1c00_0000);
    @(negedge clk);
    chk("sim_ctl_inst", {u_if.bus_wr, u_if.bus_size, u_if.bus_wstrb}, {1'b0, 2'd2, 4'hf});
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("sim_outstanding", outstanding, 2);
    next_cyc();
    respond(32'h11);
    respond(32'h22);
    @(negedge clk);
    chk("sim_out_drain", outstanding, 0);
    drained("sim");
    next_cyc();

    // ---- lock: data stalls, inst arrives meanwhile
    u_if.data_req  = 1'b1;
    u_if.data_addr = 32'h2000;
    @(negedge clk);
    chk("lock_c1_req", u_if.bus_req, 1);
    chk("lock_c1_addr", u_if.bus_addr, 32'h2000);
    next_cyc();
    u_if.inst_req  = 1'b1;
    u_if.inst_addr = 32'h3000;
    @(negedge clk);
    chk("lock_c2_addr", u_if.bus_addr, 32'h2000);
    next_cyc();
    @(negedge clk);
    chk("lock_c3_addr", u_if.bus_addr, 32'h2000);
    next_cyc();
    u_if.bus_addr_ok = 1'b1;
    exp_accept(1'b1, 32'h2000);
    @(negedge clk);
    next_cyc();
    u_if.data_req = 1'b0;
    exp_accept(1'b0, 32'h3000);
    @(negedge clk);
    chk("lock_inst_addr", u_if.bus_addr, 32'h3000);
    next_cyc();
    idle_in();
    respond(32'h33);
    respond(32'h44);
    drained("lock");

    // ---- locked master drops its request: no bus_req that cycle
    u_if.data_req  = 1'b1;
    u_if.data_addr = 32'h2800;
    @(negedge clk);
    next_cyc();
    u_if.data_req  = 1'b0;
    u_if.inst_req  = 1'b1;
    u_if.inst_addr = 32'h3800;
    u_if.bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("drop_bus_req", u_if.bus_req, 0);
    next_cyc();
    exp_accept(1'b0, 32'h3800);
    @(negedge clk);
    next_cyc();
    idle_in();
    respond(32'h3838);
    drained("drop");

    // ---- ordering I,D,I
    accept_one(1'b0, 32'h100);
    accept_one(1'b1, 32'h200);
    accept_one(1'b0, 32'h104);
    respond(32'hA);
    respond(32'hB);
    respond(32'hC);
    drained("order");

    // ---- full: four accepted, grants blocked until one pops
    for (int unsigned i = 0; i < 4; i++) accept_one(1'b0, 32'h400 + 4 * i);
    u_if.inst_req    = 1'b1;
    u_if.inst_addr   = 32'h410;
    u_if.bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("full_outstanding", outstanding, 4);
    chk("full_bus_req0", u_if.bus_req, 0);
    next_cyc();
    @(negedge clk);
    chk("full_bus_req1", u_if.bus_req, 0);
    next_cyc();
    u_if.bus_data_ok = 1'b1;
    u_if.bus_rdata   = 32'h55;
    exp_resp(32'h55);
    @(negedge clk);
    chk("full_pop_cycle_req", u_if.bus_req, 0);
    next_cyc();
    u_if.bus_data_ok = 1'b0;
    exp_accept(1'b0, 32'h410);
    @(negedge clk);
    chk("full_resume_req", u_if.bus_req, 1);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("full_refill", outstanding, 4);
    next_cyc();
    for (int unsigned i = 0; i < 4; i++) respond(32'h61 + i);
    drained("full");

    // ---- push and pop in the same cycle at outstanding=2
    accept_one(1'b1, 32'h600);
    accept_one(1'b0, 32'h604);
    u_if.data_req    = 1'b1;
    u_if.data_addr   = 32'h608;
    u_if.bus_addr_ok = 1'b1;
    u_if.bus_data_ok = 1'b1;
    u_if.bus_rdata   = 32'h77;
    exp_resp(32'h77);
    exp_accept(1'b1, 32'h608);
    @(negedge clk);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("pp_outstanding", outstanding, 2);
    next_cyc();
    respond(32'h78);
    respond(32'h79);
    drained("pp");

    // ---- stray response with an empty FIFO
    u_if.bus_data_ok = 1'b1;
    u_if.bus_rdata   = 32'h99;
    @(negedge clk);
    chk("stray_data_ok", {u_if.inst_data_ok, u_if.data_data_ok}, 0);
    next_cyc();
    u_if.bus_data_ok = 1'b0;
    @(negedge clk);
    chk("stray_outstanding", outstanding, 0);
    next_cyc();

    // ---- reset mid-LOCK with three outstanding
    for (int unsigned i = 0; i < 3; i++) accept_one(1'b0, 32'h700 + 4 * i);
    u_if.data_req  = 1'b1;
    u_if.data_addr = 32'h800;
    @(negedge clk);
    chk("rl_bus_req", u_if.bus_req, 1);
    next_cyc();
    @(negedge clk);
    chk("rl_out_before", outstanding, 3);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    addr_q.delete();
    resp_q.delete();
    tag_q.delete();
    #1;
    chk("rl_bus_req_rst", u_if.bus_req, 0);
    chk("rl_out_rst", outstanding, 0);
    @(negedge clk);
    next_cyc();
    u_if.data_req = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    next_cyc();
    u_if.bus_data_ok = 1'b1;
    u_if.bus_rdata   = 32'hee;
    @(negedge clk);
    chk("rl_no_data_ok", {u_if.inst_data_ok, u_if.data_data_ok}, 0);
    next_cyc();
    u_if.bus_data_ok = 1'b0;
    @(negedge clk);
    chk("rl_out_after", outstanding, 0);
    next_cyc();

    // ---- both requesters held for four accepted cycles after reset
`ifdef ARB_ROUND_ROBIN_EN
    pat = 4'b0101;   // k=0..3 : D,I,D,I
`else
    pat = 4'b1111;   // k=0..3 : D,D,D,D
`endif
    ia = 32'h900;
    da = 32'hA00;
    u_if.inst_req    = 1'b1;
    u_if.data_req    = 1'b1;
    u_if.bus_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      who = pat[k];
      u_if.inst_addr = ia;
      u_if.data_addr = da;
      exp_accept(who, who ? da : ia);
      @(negedge clk);
      next_cyc();
      if (who) da = da + 4;
      else     ia = ia + 4;
    end
    idle_in();
    @(negedge clk);
    chk("arb_outstanding", outstanding, 4);
    next_cyc();
    for (int unsigned i = 0; i < 4; i++) respond(32'hC0 + i);
    drained("arb");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one sram-like memory port between the fetch-stage instruction requester and the EXE-stage data requester (req/wr/size/wstrb/addr/wdata, addr_ok/data_ok/rdata).
- Grants one address handshake per cycle and records each accepted request's owner in an in-order tag FIFO.
- Routes each returning data_ok/rdata to the owning requester.
- Sits between the pipeline stages and the sram-to-AXI bridge.

Parameters:
- OUTSTANDING, 4, maximum accepted-but-unanswered requests (tag FIFO depth, power of 2, >=2).
- CNT_W, 3, width of the outstanding counter; must hold OUTSTANDING.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- inst_req  input  1  fetch request, held until inst_addr_ok
- inst_wr  input  1  write flag (normally 0)
- inst_size  input  2  0=byte, 1=half, 2=word
- inst_wstrb  input  4  byte strobes
- inst_addr  input  32  address
- inst_wdata  input  32  write data
- inst_addr_ok  output  1  fetch request accepted this cycle
- inst_data_ok  output  1  fetch response valid
- inst_rdata  output  32  fetch response data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  input  1/1/2/4/32/32  EXE data request, same rules as inst_*
- data_addr_ok  output  1  data request accepted
- data_data_ok  output  1  data response valid
- data_rdata  output  32  data response data
- bus_req  output  1  request to the bridge
- bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  output  1/2/4/32/32  muxed request fields of the granted master
- bus_addr_ok  input  1  bridge accepted request
- bus_data_ok  input  1  bridge response, returned in acceptance order
- bus_rdata  input  32  bridge response data
- outstanding  output  CNT_W  current FIFO occupancy, for debug

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, FIFO empty, outstanding=0, rr_last=0.
- Reset outputs: bus_req=0, all *_addr_ok=0, all *_data_ok=0.
- In-flight bridge transactions are dropped on reset; the bridge is reset at the same time.
- FSM IDLE:
  - If FIFO full: bus_req=0, stay in IDLE.
  - Otherwise pick a winner combinationally. Default priority: data over inst.
  - Drive bus_req=1 and the winner's fields in the same cycle.
  - If bus_addr_ok=1 this cycle: pulse the winner's *_addr_ok, push the tag (0=inst, 1=data), stay in IDLE.
  - Otherwise latch the winner into grant_r and go to LOCK.
- FSM LOCK:
  - bus_req=1 with grant_r's fields, regardless of the other requester. The bridge sees stable fields until accepted.
  - On bus_addr_ok: pulse grant_r's addr_ok, push tag, return to IDLE.
  - If the locked master drops req (illegal): deassert bus_req, return to IDLE, push nothing.
- Latency: a request reaches bus_req in the same cycle (0 cycles). addr_ok is combinational from bus_addr_ok.
- Throughput: one acceptance per cycle, provided the FIFO is not full.
- Tag FIFO:
  - Circular buffer with OUTSTANDING entries; head/tail pointers wrap modulo OUTSTANDING.
  - Push on an accepted request; pop on bus_data_ok.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full: no grants. A pop in the same cycle does not unblock; the grant resumes the next cycle.
  - Push when full cannot occur.
- Response routing:
  - inst_data_ok = bus_data_ok & !head_tag; data_data_ok = bus_data_ok & head_tag.
  - inst_rdata = data_rdata = bus_rdata, unconditionally.
  - bus_data_ok with FIFO empty is ignored: no pop, no pulse, counter stays 0.
- No other state exists. Write responses are routed identically to read responses.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - When both requesters are active in IDLE, the winner is the one not equal to rr_last.
  - rr_last updates to the winner's tag on every accepted grant.
  - LOCK behaviour is unchanged.
- Undefined: fixed data-over-inst priority; the rr_last register is not built.

Test Plan:
- Reset: drive resetn=0 mid-LOCK with 3 entries outstanding -> bus_req=0, outstanding=0 immediately; a following bus_data_ok produces no *_data_ok.
- Simultaneous requests:
  - inst_req=data_req=1, data_addr=0x1000, inst_addr=0x1c000000, bus_addr_ok=1 every cycle.
  - Expected cycle 1: bus_addr=0x1000, data_addr_ok=1. Cycle 2: bus_addr=0x1c000000, inst_addr_ok=1.
  - With ARB_ROUND_ROBIN_EN and both held 4 cycles: grants alternate D,I,D,I.
- Lock:
  - data_req=1, bus_addr_ok=0 for 3 cycles, inst_req raised in cycle 2.
  - Expected: bus_addr stays data_addr throughout. On bus_addr_ok, data_addr_ok=1 and inst_addr_ok=0. inst is granted the next cycle.
- Ordering: accept I,D,I then return three bus_data_ok with rdata 0xA,0xB,0xC -> inst_data_ok with 0xA, data_data_ok with 0xB, inst_data_ok with 0xC.
- Full:
  - With OUTSTANDING=4, accept 4 requests without responses -> outstanding=4, bus_req=0 while requests are pending.
  - One bus_data_ok -> bus_req=1 on the next cycle.
- Push/pop same cycle and stray response:
  - bus_addr_ok and bus_data_ok together at outstanding=2 -> outstanding stays 2 and tags stay in order.
  - bus_data_ok at outstanding=0 -> no *_data_ok pulse, counter stays 0.
